// File: rtl/apb_txn_scheduler.sv
// apb_txn_scheduler
// Bridges AXI4-Lite read/write requests onto a single APB master port.
// Reads and writes are arbitrated round-robin, starting with read after reset.
// Each transaction runs the APB SETUP/ACCESS sequence and returns exactly one
// AXI response.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has
// waited TIMEOUT_CYC cycles without pready. The abort returns SLVERR.
module apb_txn_scheduler #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  s_axi_clk,
   input  logic                  s_axi_areset,
   // AXI4-Lite write address
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   // AXI4-Lite write data
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   // AXI4-Lite write response
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   // AXI4-Lite read address
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   // AXI4-Lite read data / response
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   // APB master
   output logic [ADDR_W-1:0]     m_apb_paddr,
   output logic                  m_apb_psel,
   output logic                  m_apb_penable,
   output logic                  m_apb_pwrite,
   output logic [DATA_W-1:0]     m_apb_pwdata,
   output logic [DATA_W/8-1:0]   m_apb_pstrb,
   output logic [2:0]            m_apb_pprot,
   input  logic [DATA_W-1:0]     m_apb_prdata,
   input  logic                  m_apb_pready,
   input  logic                  m_apb_pslverr
);

   localparam int STRB_W = DATA_W / 8;

   // A timeout shorter than two ACCESS cycles cannot be honoured.
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("apb_txn_scheduler: TIMEOUT_CYC must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_q,  state_d;
   logic                prio_wr_q, prio_wr_d;  // 1: a write wins the next tie
   logic                write_q,  write_d;     // direction of the captured request
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [STRB_W-1:0]   wstrb_q,  wstrb_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic                slverr_q, slverr_d;

`ifdef APB_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYC);
   logic [TCNT_W-1:0]   tcnt_q,   tcnt_d;      // consecutive pready=0 cycles in ACCESS
`endif

   logic rd_elig, wr_elig;
   logic grant_rd, grant_wr;
   logic in_idle, in_resp;

   // Request eligibility and round-robin grant.
   // A write needs its address and data presented together.
   always_comb begin
      in_idle  = (state_q == IDLE);
      in_resp  = (state_q == RESP);
      rd_elig  = s_axi_arvalid;
      wr_elig  = s_axi_awvalid && s_axi_wvalid;
      grant_rd = in_idle && rd_elig && (!wr_elig || !prio_wr_q);
      grant_wr = in_idle && wr_elig && (!rd_elig ||  prio_wr_q);
   end

   // The readies are combinational so that acceptance happens in the IDLE cycle.
   assign s_axi_arready = grant_rd;
   assign s_axi_awready = grant_wr;
   assign s_axi_wready  = grant_wr;

   // APB outputs come only from registered state and captured request fields.
   // This keeps them stable from SETUP through the final ACCESS cycle.
   assign m_apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
   assign m_apb_penable = (state_q == ACCESS);
   assign m_apb_pwrite  = write_q;
   assign m_apb_paddr   = addr_q;
   assign m_apb_pwdata  = wdata_q;
   assign m_apb_pstrb   = wstrb_q;
   assign m_apb_pprot   = 3'b000;

   // AXI responses are presented while in RESP, on the channel that matches the direction.
   assign s_axi_bvalid = in_resp &&  write_q;
   assign s_axi_rvalid = in_resp && !write_q;
   assign s_axi_bresp  = (in_resp &&  write_q && slverr_q) ? 2'b10 : 2'b00;
   assign s_axi_rresp  = (in_resp && !write_q && slverr_q) ? 2'b10 : 2'b00;
   assign s_axi_rdata  = rdata_q;

   // Next-state and capture logic for the transaction sequencer.
   always_comb begin
      state_d   = state_q;
      prio_wr_d = prio_wr_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
`ifdef APB_TIMEOUT_EN
      tcnt_d    = tcnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_rd) begin
               // Reads carry no write data; zero it so APB never sees stale data.
               write_d   = 1'b0;
               addr_d    = s_axi_araddr;
               wdata_d   = '0;
               wstrb_d   = '0;
               slverr_d  = 1'b0;
               prio_wr_d = 1'b1;
               state_d   = SETUP;
            end else if (grant_wr) begin
               write_d   = 1'b1;
               addr_d    = s_axi_awaddr;
               wdata_d   = s_axi_wdata;
               wstrb_d   = s_axi_wstrb;
               slverr_d  = 1'b0;
               prio_wr_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
            tcnt_d  = '0;
`endif
         end
         ACCESS: begin
            if (m_apb_pready) begin
               // Completion wins over a timeout that would expire in the same cycle.
               if (!write_q) begin
                  rdata_d = m_apb_prdata;
               end
               slverr_d = m_apb_pslverr;
               state_d  = RESP;
            end
`ifdef APB_TIMEOUT_EN
            else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
               // Hung completer: give up and report SLVERR with no read data.
               if (!write_q) begin
                  rdata_d = '0;
               end
               slverr_d = 1'b1;
               state_d  = RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if (write_q ? s_axi_bready : s_axi_rready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and capture registers. Reset drops any in-flight transaction without a response.
   always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         state_q   <= IDLE;
         prio_wr_q <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_wr_q <= prio_wr_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   // Counter for the hung-completer timeout.
   always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`endif

endmodule
